// File: rtl/legv8_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller: FSM states, opcode
// patterns, ALU operand/operation selects and fault cause codes.
package legv8_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BR_CBZ = 4'd9,
        S_BR_B   = 4'd10,
        S_FAULT  = 4'd11
    } ctrlState_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LDUR    = 3'd1,
        CLS_STUR    = 3'd2,
        CLS_CBZ     = 3'd3,
        CLS_B       = 3'd4,
        CLS_ILLEGAL = 3'd5
    } opClass_e;

    // Full 11-bit opcodes
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // CB and B formats carry immediate bits inside the 11-bit field
    localparam logic [10:0] MASK_CBZ = 11'b11111111000;
    localparam logic [10:0] OP_CBZ   = 11'b10110100000;
    localparam logic [10:0] MASK_B   = 11'b11111100000;
    localparam logic [10:0] OP_B     = 11'b00010100000;

    localparam logic [1:0] SRCB_BREG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/legv8_opcode_decode.sv
// Combinational classification of the IR opcode field into the instruction
// groups the sequencer branches on.
module legv8_opcode_decode
    import legv8_pkg::*;
(
    input  logic [10:0] opcode,
    output opClass_e    opClass
);

    // Exact matches first, then the masked branch formats; anything else is illegal
    always_comb begin
        opClass = CLS_ILLEGAL;
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
            opClass = CLS_RTYPE;
        else if (opcode == OP_LDUR)
            opClass = CLS_LDUR;
        else if (opcode == OP_STUR)
            opClass = CLS_STUR;
        else if ((opcode & MASK_CBZ) == OP_CBZ)
            opClass = CLS_CBZ;
        else if ((opcode & MASK_B) == OP_B)
            opClass = CLS_B;
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencer sharing one memory port between fetch and data
// access. Outputs are decoded from the state register, so an asynchronous
// reset drops every strobe in the same instant.
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg2loc,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    ctrlState_e        state, nextState;
    opClass_e          opClass;
    logic [WAIT_W-1:0] waitCnt;
    logic              retireNow;
    logic              waitState;
    logic              timedOut;

    legv8_opcode_decode uDecode (
        .opcode  (opcode),
        .opClass (opClass)
    );

    // Memory-facing states are the only ones that can stall
    assign waitState = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // A ready on the last allowed cycle still completes the access
    assign timedOut  = waitState && !mem_ready && (waitCnt == WAIT_LAST);

    // Next-state selection and retire detection
    always_comb begin
        nextState = state;
        retireNow = 1'b0;
        case (state)
            S_IDLE:   nextState = S_FETCH;
            S_FETCH:  if (mem_ready) nextState = S_DECODE;
                      else if (timedOut) nextState = S_FAULT;
            S_DECODE: begin
                case (opClass)
                    CLS_RTYPE:          nextState = S_EXEC_R;
                    CLS_LDUR, CLS_STUR: nextState = S_ADDR;
                    CLS_CBZ:            nextState = S_BR_CBZ;
                    CLS_B:              nextState = S_BR_B;
                    default:            nextState = S_FAULT;
                endcase
            end
            S_EXEC_R: nextState = S_WB_R;
            S_WB_R:   begin nextState = S_FETCH; retireNow = 1'b1; end
            S_ADDR:   nextState = (opClass == CLS_STUR) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (mem_ready) nextState = S_WB_MEM;
                      else if (timedOut) nextState = S_FAULT;
            S_WB_MEM: begin nextState = S_FETCH; retireNow = 1'b1; end
            S_MEM_WR: if (mem_ready) begin nextState = S_FETCH; retireNow = 1'b1; end
                      else if (timedOut) nextState = S_FAULT;
            S_BR_CBZ: begin nextState = S_FETCH; retireNow = 1'b1; end
            S_BR_B:   begin nextState = S_FETCH; retireNow = 1'b1; end
            S_FAULT:  nextState = S_FAULT;
            default:  nextState = S_IDLE;
        endcase
    end

    // State register, stall timer, retire counter and sticky fault capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            waitCnt    <= '0;
            retired    <= '0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
        end else begin
            state <= nextState;
            if (nextState != state)
                waitCnt <= '0;
            else if (waitState && !mem_ready)
                waitCnt <= waitCnt + WAIT_ONE;
            if (retireNow)
                retired <= retired + CNT_ONE;
            // Only the first cause is recorded; FAULT is never left without reset
            if (nextState == S_FAULT && !fault) begin
                fault      <= 1'b1;
                fault_code <= (state == S_DECODE) ? FAULT_ILLEGAL : FAULT_TIMEOUT;
            end
        end
    end

    // Moore decode of the datapath controls; fetch strobes wait for the memory
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg2loc    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_BREG;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_SEXT_SH2;
                reg2loc   = (opClass == CLS_LDUR) || (opClass == CLS_STUR) || (opClass == CLS_CBZ);
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_WB_R:   reg_write = 1'b1;
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SEXT;
                reg2loc   = 1'b1;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                reg2loc   = 1'b1;
            end
            S_BR_CBZ: begin
                reg2loc  = 1'b1;
                alu_op   = ALUOP_PASSB;
                pc_write = zero;
                pc_src   = 1'b1;
            end
            S_BR_B: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for the LEGv8 multi-cycle controller. Each instruction is expanded into
// a per-cycle plan (inputs to drive, control word expected, whether it retires)
// from the instruction-level timing rules, then played against the DUT.
module tb_legv8_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;   // small so the retire counter wraps during the run

    localparam int C_R = 0, C_LDUR = 1, C_STUR = 2, C_CBZ = 3, C_B = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [10:0]      opcode = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_src, ir_write, iord, mem_read, mem_write;
    logic             reg_write, mem_to_reg, reg2loc, alu_src_a, fault;
    logic [1:0]       alu_src_b, alu_op, fault_code;
    logic [CNT_W-1:0] retired;

    legv8_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .reg2loc(reg2loc), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .fault(fault), .fault_code(fault_code),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] ctl;
        logic        rdy;
        logic        z;
        logic        ret;
        string       name;
    } cyc_t;

    cyc_t             plan[$];
    int               checkCnt = 0;
    int               passCnt = 0;
    int               failCnt = 0;
    logic [CNT_W-1:0] expRetired = '0;

    wire [13:0] obsCtl = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                          reg_write, mem_to_reg, reg2loc, alu_src_a, alu_src_b, alu_op};

    function automatic logic [13:0] mk(input logic pcw, input logic pcs, input logic irw,
                                       input logic io, input logic mr, input logic mw,
                                       input logic rw, input logic m2r, input logic r2l,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop);
        return {pcw, pcs, irw, io, mr, mw, rw, m2r, r2l, asa, asb, aop};
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic void add(input logic [13:0] c, input logic rdy, input logic z,
                                input logic ret, input string name);
        cyc_t e;
        e.ctl = c; e.rdy = rdy; e.z = z; e.ret = ret; e.name = name;
        plan.push_back(e);
    endfunction

    function automatic logic [10:0] genOp(input int cls);
        logic [10:0] op;
        case (cls)
            C_R: begin
                case ($urandom_range(0, 3))
                    0:       op = 11'b10001011000;
                    1:       op = 11'b11001011000;
                    2:       op = 11'b10001010000;
                    default: op = 11'b10101010000;
                endcase
            end
            C_LDUR:  op = 11'b11111000010;
            C_STUR:  op = 11'b11111000000;
            C_CBZ:   op = {8'b10110100, 3'($urandom)};
            C_B:     op = {6'b000101, 5'($urandom)};
            default: op = 11'b11111111111;
        endcase
        return op;
    endfunction

    // Fetch with fw stall cycles, decode, then the class-specific tail.
    // zsel < 0 means the zero flag is random in the branch cycle.
    function automatic void buildInstr(input int cls, input int fw, input int mwt, input int zsel);
        logic r2l, z;
        for (int i = 0; i < fw; i++)
            add(mk(0,0,0,0,1,0,0,0,0,0,2'b01,2'b00), 1'b0, rbit(), 1'b0, "fetch_wait");
        add(mk(1,0,1,0,1,0,0,0,0,0,2'b01,2'b00), 1'b1, rbit(), 1'b0, "fetch_done");
        r2l = (cls == C_LDUR) || (cls == C_STUR) || (cls == C_CBZ);
        add(mk(0,0,0,0,0,0,0,0,r2l,0,2'b11,2'b00), rbit(), rbit(), 1'b0, "decode");
        case (cls)
            C_R: begin
                add(mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10), rbit(), rbit(), 1'b0, "exec_r");
                add(mk(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00), rbit(), rbit(), 1'b1, "wb_r");
            end
            C_LDUR: begin
                add(mk(0,0,0,0,0,0,0,0,1,1,2'b10,2'b00), rbit(), rbit(), 1'b0, "addr");
                for (int i = 0; i < mwt; i++)
                    add(mk(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00), 1'b0, rbit(), 1'b0, "mem_rd_wait");
                add(mk(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00), 1'b1, rbit(), 1'b0, "mem_rd_done");
                add(mk(0,0,0,0,0,0,1,1,0,0,2'b00,2'b00), rbit(), rbit(), 1'b1, "wb_mem");
            end
            C_STUR: begin
                add(mk(0,0,0,0,0,0,0,0,1,1,2'b10,2'b00), rbit(), rbit(), 1'b0, "addr");
                for (int i = 0; i < mwt; i++)
                    add(mk(0,0,0,1,0,1,0,0,1,0,2'b00,2'b00), 1'b0, rbit(), 1'b0, "mem_wr_wait");
                add(mk(0,0,0,1,0,1,0,0,1,0,2'b00,2'b00), 1'b1, rbit(), 1'b1, "mem_wr_done");
            end
            C_CBZ: begin
                z = (zsel < 0) ? rbit() : 1'(zsel);
                add(mk(z,1,0,0,0,0,0,0,1,0,2'b00,2'b01), rbit(), z, 1'b1, "br_cbz");
            end
            default:
                add(mk(1,1,0,0,0,0,0,0,0,0,2'b00,2'b00), rbit(), rbit(), 1'b1, "br_b");
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive each planned cycle just after the rising edge, check on the falling edge
    task automatic runPlan(input logic [10:0] op);
        cyc_t c;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            opcode = op; mem_ready = c.rdy; zero = c.z;
            @(negedge clk);
            chk({c.name, "_ctl"}, 32'(obsCtl), 32'(c.ctl));
            chk({c.name, "_retired"}, 32'(retired), 32'(expRetired));
            chk({c.name, "_fault"}, 32'({fault, fault_code}), 32'(0));
            @(posedge clk); #1;
            if (c.ret) expRetired = expRetired + 1'b1;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        chk("rst_ctl", 32'(obsCtl), 32'(0));
        chk("rst_retired", 32'(retired), 32'(0));
        chk("rst_fault", 32'({fault, fault_code}), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        expRetired = '0;
        add(14'd0, rbit(), rbit(), 1'b0, "idle");
        runPlan(11'd0);
    endtask

    initial begin
        logic [10:0] op;
        int          cls;

        // Reset state, then ADD with no memory stalls
        @(negedge clk);
        doReset();
        buildInstr(C_R, 0, 0, -1);
        runPlan(11'b10001011000);

        // LDUR stalled three cycles in the data read
        buildInstr(C_LDUR, 0, 3, -1);
        runPlan(11'b11111000010);

        // CBZ taken and not taken; both retire
        buildInstr(C_CBZ, 0, 0, 1);
        runPlan(genOp(C_CBZ));
        buildInstr(C_CBZ, 0, 0, 0);
        runPlan(genOp(C_CBZ));

        buildInstr(C_B, 0, 0, -1);
        runPlan(genOp(C_B));
        buildInstr(C_STUR, 1, 2, -1);
        runPlan(11'b11111000000);

        // Ready arriving on the last permitted fetch cycle completes the fetch
        buildInstr(C_R, MEM_TIMEOUT - 1, 0, -1);
        runPlan(genOp(C_R));
        buildInstr(C_LDUR, 0, MEM_TIMEOUT - 1, -1);
        runPlan(11'b11111000010);

        // Random instruction mix with short stalls; counter wraps along the way
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 4);
            op  = genOp(cls);
            buildInstr(cls, $urandom_range(0, 3), $urandom_range(0, 3), -1);
            runPlan(op);
        end

        // Illegal opcode: fault after decode, held regardless of inputs
        add(mk(1,0,1,0,1,0,0,0,0,0,2'b01,2'b00), 1'b1, 1'b0, 1'b0, "ill_fetch");
        add(mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00), 1'b0, 1'b0, 1'b0, "ill_decode");
        runPlan(11'b11111111111);
        for (int i = 0; i < 50; i++) begin
            mem_ready = rbit(); zero = rbit(); opcode = 11'($urandom);
            @(negedge clk);
            chk("ill_ctl", 32'(obsCtl), 32'(0));
            chk("ill_fault", 32'({fault, fault_code}), 32'({1'b1, 2'b01}));
            chk("ill_retired", 32'(retired), 32'(expRetired));
            @(posedge clk); #1;
        end

        // Fetch never completes: fault with timeout code after MEM_TIMEOUT cycles
        doReset();
        for (int i = 0; i < MEM_TIMEOUT; i++)
            add(mk(0,0,0,0,1,0,0,0,0,0,2'b01,2'b00), 1'b0, rbit(), 1'b0, "to_fetch");
        runPlan(11'b10001011000);
        for (int i = 0; i < 5; i++) begin
            mem_ready = rbit();
            @(negedge clk);
            chk("to_ctl", 32'(obsCtl), 32'(0));
            chk("to_fault", 32'({fault, fault_code}), 32'({1'b1, 2'b10}));
            @(posedge clk); #1;
        end

        // Reset in the middle of a stalled store, then a clean restart
        doReset();
        buildInstr(C_B, 0, 0, -1);
        runPlan(genOp(C_B));
        add(mk(1,0,1,0,1,0,0,0,0,0,2'b01,2'b00), 1'b1, 1'b0, 1'b0, "st_fetch");
        add(mk(0,0,0,0,0,0,0,0,1,0,2'b11,2'b00), 1'b0, 1'b0, 1'b0, "st_decode");
        add(mk(0,0,0,0,0,0,0,0,1,1,2'b10,2'b00), 1'b0, 1'b0, 1'b0, "st_addr");
        add(mk(0,0,0,1,0,1,0,0,1,0,2'b00,2'b00), 1'b0, 1'b0, 1'b0, "st_mem_wr");
        runPlan(11'b11111000000);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("st_mem_write_before", 32'(mem_write), 32'(1));
        chk("st_retired_before", 32'(retired), 32'(1));
        #2;
        doReset();
        buildInstr(C_R, 2, 0, -1);
        runPlan(genOp(C_R));
        buildInstr(C_STUR, 0, 0, -1);
        runPlan(11'b11111000000);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
